linha_envase_multicanal: RTL and testbench
==========================================

LINHA_ENVASE_MULTICANAL -- requirements
Module: linha_envase_multicanal

Interface
REQ-001 Parameter N_LINHAS, default 2, number of parallel filling lanes (1..4).
REQ-002 Parameter T_ENCHE_MAX, default 15, maximum ENCHENDO cycles before fill fault.
REQ-003 Parameter ESTOQUE_INICIAL, default 20, cork stock loaded at reset.
REQ-004 Parameter LOTE_ROLHAS, default 20, corks added per ADD_ROLHAS pulse.
REQ-005 Parameter ESTOQUE_MAX, default 150, stock saturation value.
REQ-006 Parameter META_DUZIAS, default 10, dozen target.
REQ-007 CLOCK  in  1  single system clock; all logic on the rising edge.
REQ-008 RESET  in  1  synchronous, active-low reset.
REQ-009 START  in  1  level; 1 = line running.
REQ-010 GARRAFA_PRESENTE  in  N_LINHAS  per-lane bottle-in-position sensor.
REQ-011 SENSOR_NIVEL  in  N_LINHAS  per-lane full-level sensor.
REQ-012 PULSO_APROVADA / PULSO_REPROVADA  in  N_LINHAS each  one-cycle inspection results.
REQ-013 ADD_ROLHAS  in  1  one-cycle cork refill pulse.
REQ-014 LIMPA_FALHA  in  N_LINHAS  one-cycle per-lane fault clear.
REQ-015 MOTOR_ATIVO, VALVULA_EV, GARRAFA_VEDADA, LACRE, DESCARTE, FALHA_ENCHIMENTO  out  N_LINHAS each  per-lane status.
REQ-016 COUNT_GA  out  4  bottles in current dozen (0..11); COUNT_DU  out  4  dozens (0..META_DUZIAS).
REQ-017 ESTOQUE  out  8  corks in stock; SEM_ROLHAS  out  1; META_ATINGIDA  out  1.

Function
REQ-018 Each lane SHALL run an independent FSM: ESPERA, ENCHENDO, VEDANDO, INSPECAO, LACRE, DESCARTE, SAIDA, FALHA.
REQ-019 ESPERA: MOTOR_ATIVO=START & !META_ATINGIDA & !SEM_ROLHAS; START & GARRAFA_PRESENTE & !META_ATINGIDA -> ENCHENDO with the fill timer cleared.
REQ-020 ENCHENDO: VALVULA_EV=1; SENSOR_NIVEL=1 -> VEDANDO; otherwise, timer reaching T_ENCHE_MAX or GARRAFA_PRESENTE=0 -> FALHA; SENSOR_NIVEL takes priority over timeout in the same cycle.
REQ-021 VEDANDO: lane requests a cork; on grant -> INSPECAO; with ESTOQUE=0 the lane waits indefinitely.
REQ-022 Arbiter SHALL be round-robin: at most one grant per cycle, to the first requester at or after pointer; pointer <- granted index+1 mod N_LINHAS; pointer holds with no grant.
REQ-023 INSPECAO: GARRAFA_VEDADA=1; PULSO_REPROVADA -> DESCARTE; PULSO_APROVADA alone -> LACRE; both in the same cycle -> DESCARTE.
REQ-024 LACRE and DESCARTE SHALL last exactly one cycle each (output high), then -> SAIDA.
REQ-025 SAIDA: MOTOR_ATIVO=1; GARRAFA_PRESENTE=0 -> ESPERA.
REQ-026 FALHA: FALHA_ENCHIMENTO=1, valve off, motor off; LIMPA_FALHA -> SAIDA.
REQ-027 START=0 SHALL force every lane to ESPERA next cycle, all lane outputs 0; counters, stock and pointer hold.
REQ-028 Stock: grant -> -1; ADD_ROLHAS -> +LOTE_ROLHAS, saturating at ESTOQUE_MAX; both in the same cycle -> net +LOTE_ROLHAS-1, saturating.
REQ-029 SEM_ROLHAS SHALL equal (ESTOQUE==0) combinationally.
REQ-030 Bottle counter SHALL add popcount(LACRE) per cycle; if the sum is >=12, COUNT_GA <- sum-12 and COUNT_DU increments.
REQ-031 COUNT_DU SHALL saturate at META_DUZIAS; META_ATINGIDA=(COUNT_DU==META_DUZIAS); once it is set, COUNT_GA and COUNT_DU hold, and in-flight bottles complete.

Reset
REQ-032 RESET=0 at an edge SHALL put all lanes in ESPERA, set COUNT_GA=0, COUNT_DU=0, ESTOQUE=ESTOQUE_INICIAL and pointer=0, and drive all lane outputs 0 at the next edge; RESET overrides every other input.

Verification
REQ-033 Single lane nominal: START=1, GP0=1, NIVEL0=1 after 3 cycles, APROVADA0 pulse -> VALVULA_EV0 high for 4 cycles, ESTOQUE 20->19, LACRE0 pulses once, COUNT_GA=1.
REQ-034 Contention: lanes 0 and 1 enter VEDANDO in the same cycle with pointer=0 -> lane 0 is granted first and lane 1 on the next cycle; ESTOQUE decreases by 2 over 2 cycles.
REQ-035 Timeout: GP0=1 and NIVEL0 held at 0 -> FALHA_ENCHIMENTO0=1 after 15 cycles; LIMPA_FALHA0 -> SAIDA, then ESPERA once GP0=0.
REQ-036 Stock boundary: ESTOQUE=0 with lane in VEDANDO -> lane holds and SEM_ROLHAS=1; ADD_ROLHAS in the same cycle as the grant -> ESTOQUE=19.
REQ-037 Dozen and target: COUNT_GA=11 and two simultaneous LACRE -> COUNT_GA=1 and COUNT_DU+1; at COUNT_DU=10, META_ATINGIDA=1, no new fills start and the counters hold.
REQ-038 Mid-operation reset: RESET=0 while a lane is in ENCHENDO -> next cycle VALVULA_EV=0, ESTOQUE=20, counters 0.

Source files
------------

// File: rtl/linha_envase_multicanal.sv
// Multi-lane bottle filling line: one FSM per lane, a round-robin cork arbiter,
// a shared saturating cork stock and a dozen counter with a production target.
module linha_envase_multicanal #(
    parameter int N_LINHAS        = 2,
    parameter int T_ENCHE_MAX     = 15,
    parameter int ESTOQUE_INICIAL = 20,
    parameter int LOTE_ROLHAS     = 20,
    parameter int ESTOQUE_MAX     = 150,
    parameter int META_DUZIAS     = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [N_LINHAS-1:0] garrafa_presente,
    input  logic [N_LINHAS-1:0] sensor_nivel,
    input  logic [N_LINHAS-1:0] pulso_aprovada,
    input  logic [N_LINHAS-1:0] pulso_reprovada,
    input  logic                add_rolhas,
    input  logic [N_LINHAS-1:0] limpa_falha,
    output logic [N_LINHAS-1:0] motor_ativo,
    output logic [N_LINHAS-1:0] valvula_ev,
    output logic [N_LINHAS-1:0] garrafa_vedada,
    output logic [N_LINHAS-1:0] lacre,
    output logic [N_LINHAS-1:0] descarte,
    output logic [N_LINHAS-1:0] falha_enchimento,
    output logic [3:0]          count_ga,
    output logic [3:0]          count_du,
    output logic [7:0]          estoque,
    output logic                sem_rolhas,
    output logic                meta_atingida
);
    localparam int PW = (N_LINHAS > 1) ? $clog2(N_LINHAS) : 1;
    localparam int TW = $clog2(T_ENCHE_MAX + 1);

    typedef enum logic [2:0] {
        ESPERA, ENCHENDO, VEDANDO, INSPECAO, LACRE, DESCARTE, SAIDA, FALHA
    } estado_t;

    estado_t             estado  [N_LINHAS];
    estado_t             proximo [N_LINHAS];
    logic [TW-1:0]       timer   [N_LINHAS];
    logic [PW-1:0]       ponteiro;
    logic [N_LINHAS-1:0] pedido;
    logic [N_LINHAS-1:0] concessao;
    logic [PW-1:0]       idx_concessao;
    logic [PW-1:0]       candidato;
    logic                tem_concessao;
    logic                rolha_disponivel;
    logic [7:0]          estoque_nxt;
    logic [3:0]          count_ga_nxt;
    logic [3:0]          count_du_nxt;
    logic [4:0]          soma_ga;
    logic                meta_nxt;
    logic                sem_nxt;
    int                  estoque_soma;

    assign sem_rolhas    = (estoque == 8'd0);
    assign meta_atingida = (count_du == 4'(META_DUZIAS));

    // A refill arriving in the same cycle makes a cork available even from an empty stock.
    assign rolha_disponivel = start && ((estoque != 8'd0) || add_rolhas);

    always_comb begin
        pedido = '0;
        for (int i = 0; i < N_LINHAS; i++)
            pedido[i] = rolha_disponivel && (estado[i] == VEDANDO);
    end

    always_comb begin
        tem_concessao = 1'b0;
        idx_concessao = '0;
        candidato     = '0;
        concessao     = '0;
        for (int k = 0; k < N_LINHAS; k++) begin
            candidato = PW'((int'(ponteiro) + k) % N_LINHAS);
            if (!tem_concessao && pedido[candidato]) begin
                tem_concessao = 1'b1;
                idx_concessao = candidato;
            end
        end
        if (tem_concessao)
            concessao[idx_concessao] = 1'b1;
    end

    always_comb begin
        for (int i = 0; i < N_LINHAS; i++) begin
            proximo[i] = estado[i];
            if (!start) begin
                proximo[i] = ESPERA;
            end else begin
                case (estado[i])
                    ESPERA:
                        if (garrafa_presente[i] && !meta_atingida)
                            proximo[i] = ENCHENDO;
                    ENCHENDO:
                        if (sensor_nivel[i])
                            proximo[i] = VEDANDO;
                        else if ((timer[i] == TW'(T_ENCHE_MAX - 1)) || !garrafa_presente[i])
                            proximo[i] = FALHA;
                    VEDANDO:
                        if (concessao[i])
                            proximo[i] = INSPECAO;
                    INSPECAO:
                        if (pulso_reprovada[i])
                            proximo[i] = DESCARTE;
                        else if (pulso_aprovada[i])
                            proximo[i] = LACRE;
                    LACRE, DESCARTE:
                        proximo[i] = SAIDA;
                    SAIDA:
                        if (!garrafa_presente[i])
                            proximo[i] = ESPERA;
                    FALHA:
                        if (limpa_falha[i])
                            proximo[i] = SAIDA;
                    default:
                        proximo[i] = ESPERA;
                endcase
            end
        end
    end

    // Stock and counters freeze while the line is stopped; counting also stops at the target.
    always_comb begin
        estoque_soma = int'(estoque);
        if (add_rolhas)
            estoque_soma = estoque_soma + LOTE_ROLHAS;
        if (tem_concessao)
            estoque_soma = estoque_soma - 1;
        if (estoque_soma > ESTOQUE_MAX)
            estoque_soma = ESTOQUE_MAX;
        estoque_nxt = start ? 8'(estoque_soma) : estoque;

        soma_ga      = {1'b0, count_ga} + 5'($countones(lacre));
        count_ga_nxt = count_ga;
        count_du_nxt = count_du;
        if (start && !meta_atingida) begin
            if (soma_ga >= 5'd12) begin
                count_ga_nxt = 4'(soma_ga - 5'd12);
                count_du_nxt = count_du + 4'd1;
            end else begin
                count_ga_nxt = soma_ga[3:0];
            end
        end
        meta_nxt = (count_du_nxt == 4'(META_DUZIAS));
        sem_nxt  = (estoque_nxt == 8'd0);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < N_LINHAS; i++) begin
                estado[i] <= ESPERA;
                timer[i]  <= '0;
            end
            ponteiro         <= '0;
            estoque          <= 8'(ESTOQUE_INICIAL);
            count_ga         <= 4'd0;
            count_du         <= 4'd0;
            motor_ativo      <= '0;
            valvula_ev       <= '0;
            garrafa_vedada   <= '0;
            lacre            <= '0;
            descarte         <= '0;
            falha_enchimento <= '0;
        end else begin
            for (int i = 0; i < N_LINHAS; i++) begin
                estado[i] <= proximo[i];
                timer[i]  <= ((estado[i] == ENCHENDO) && (proximo[i] == ENCHENDO))
                             ? timer[i] + 1'b1 : '0;
                motor_ativo[i]      <= (proximo[i] == SAIDA) ||
                                       ((proximo[i] == ESPERA) && start && !meta_nxt && !sem_nxt);
                valvula_ev[i]       <= (proximo[i] == ENCHENDO);
                garrafa_vedada[i]   <= (proximo[i] == INSPECAO);
                lacre[i]            <= (proximo[i] == LACRE);
                descarte[i]         <= (proximo[i] == DESCARTE);
                falha_enchimento[i] <= (proximo[i] == FALHA);
            end
            if (tem_concessao)
                ponteiro <= (idx_concessao == PW'(N_LINHAS - 1)) ? '0 : idx_concessao + 1'b1;
            estoque  <= estoque_nxt;
            count_ga <= count_ga_nxt;
            count_du <= count_du_nxt;
        end
    end

endmodule

// File: tb/tb_linha_envase_multicanal.sv
// Bench for linha_envase_multicanal: a vector table, directed corner sequences and a
// randomized run, all also compared every cycle against a behavioural model of the line.
module tb_linha_envase_multicanal;
    localparam int N     = 2;
    localparam int T_MAX = 15;
    localparam int INIT  = 20;
    localparam int LOTE  = 20;
    localparam int SMAX  = 150;
    localparam int META  = 10;

    localparam int PH_IDLE  = 0;
    localparam int PH_FILL  = 1;
    localparam int PH_SEAL  = 2;
    localparam int PH_INSP  = 3;
    localparam int PH_OK    = 4;
    localparam int PH_BAD   = 5;
    localparam int PH_EXIT  = 6;
    localparam int PH_FAULT = 7;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         add   = 1'b0;
    logic [N-1:0] gp    = '0;
    logic [N-1:0] nivel = '0;
    logic [N-1:0] apr   = '0;
    logic [N-1:0] rep   = '0;
    logic [N-1:0] limpa = '0;
    logic [N-1:0] motor, valve, ved, lac, desc, falha;
    logic [3:0]   ga, du;
    logic [7:0]   est;
    logic         sem, meta;

    linha_envase_multicanal #(
        .N_LINHAS(N), .T_ENCHE_MAX(T_MAX), .ESTOQUE_INICIAL(INIT),
        .LOTE_ROLHAS(LOTE), .ESTOQUE_MAX(SMAX), .META_DUZIAS(META)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .garrafa_presente(gp), .sensor_nivel(nivel),
        .pulso_aprovada(apr), .pulso_reprovada(rep),
        .add_rolhas(add), .limpa_falha(limpa),
        .motor_ativo(motor), .valvula_ev(valve), .garrafa_vedada(ved),
        .lacre(lac), .descarte(desc), .falha_enchimento(falha),
        .count_ga(ga), .count_du(du), .estoque(est),
        .sem_rolhas(sem), .meta_atingida(meta)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    int           m_ph  [N];
    int           m_age [N];
    int           m_stock;
    int           m_total;
    int           m_ptr;
    logic [N-1:0] e_motor, e_valve, e_ved, e_lac, e_desc, e_falha;
    logic [29:0]  m_exp;

    typedef struct {
        logic         st;
        logic [N-1:0] gp;
        logic [N-1:0] niv;
        logic [N-1:0] apr;
        logic         motor0;
        logic         valve0;
        logic         ved0;
        logic         lac0;
        logic [7:0]   est;
        logic [3:0]   ga;
    } vec_t;

    vec_t tbl [9];

    function automatic logic [29:0] dut_vec();
        return {motor, valve, ved, lac, desc, falha, ga, du, est, sem, meta};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            if (n_fail <= 40)
                $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    // Reference: bottles are tracked as a running total; dozens and remainder come from division.
    task automatic model_step();
        int  gidx;
        int  nlac;
        bit  avail;
        bit  meta_old;
        bit  meta_new;
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                m_ph[i]  = PH_IDLE;
                m_age[i] = 0;
            end
            m_stock = INIT;
            m_total = 0;
            m_ptr   = 0;
            e_motor = '0; e_valve = '0; e_ved = '0; e_lac = '0; e_desc = '0; e_falha = '0;
            meta_new = (META == 0);
        end else begin
            meta_old = ((m_total / 12) >= META);
            nlac = 0;
            for (int i = 0; i < N; i++)
                if (m_ph[i] == PH_OK) nlac++;
            avail = start && ((m_stock > 0) || add);
            gidx = -1;
            if (avail)
                for (int k = 0; k < N; k++)
                    if (gidx < 0 && m_ph[(m_ptr + k) % N] == PH_SEAL)
                        gidx = (m_ptr + k) % N;
            for (int i = 0; i < N; i++) begin
                if (!start) begin
                    m_ph[i] = PH_IDLE;
                end else begin
                    case (m_ph[i])
                        PH_IDLE:
                            if (gp[i] && !meta_old) begin
                                m_ph[i]  = PH_FILL;
                                m_age[i] = 0;
                            end
                        PH_FILL:
                            if (nivel[i]) m_ph[i] = PH_SEAL;
                            else if ((m_age[i] + 1 >= T_MAX) || !gp[i]) m_ph[i] = PH_FAULT;
                            else m_age[i] = m_age[i] + 1;
                        PH_SEAL:  if (gidx == i) m_ph[i] = PH_INSP;
                        PH_INSP:
                            if (rep[i]) m_ph[i] = PH_BAD;
                            else if (apr[i]) m_ph[i] = PH_OK;
                        PH_OK, PH_BAD: m_ph[i] = PH_EXIT;
                        PH_EXIT:  if (!gp[i]) m_ph[i] = PH_IDLE;
                        PH_FAULT: if (limpa[i]) m_ph[i] = PH_EXIT;
                        default:  m_ph[i] = PH_IDLE;
                    endcase
                end
            end
            if (start) begin
                m_stock = m_stock + (add ? LOTE : 0) - ((gidx >= 0) ? 1 : 0);
                if (m_stock > SMAX) m_stock = SMAX;
                if (gidx >= 0) m_ptr = (gidx + 1) % N;
                if (!meta_old) m_total = m_total + nlac;
            end
            meta_new = ((m_total / 12) >= META);
            for (int i = 0; i < N; i++) begin
                e_motor[i] = (m_ph[i] == PH_EXIT) ||
                             ((m_ph[i] == PH_IDLE) && start && !meta_new && (m_stock > 0));
                e_valve[i] = (m_ph[i] == PH_FILL);
                e_ved[i]   = (m_ph[i] == PH_INSP);
                e_lac[i]   = (m_ph[i] == PH_OK);
                e_desc[i]  = (m_ph[i] == PH_BAD);
                e_falha[i] = (m_ph[i] == PH_FAULT);
            end
        end
        m_exp = {e_motor, e_valve, e_ved, e_lac, e_desc, e_falha,
                 4'(m_total % 12), 4'(m_total / 12), 8'(m_stock), (m_stock == 0), meta_new};
    endtask

    task automatic applyStimulus();
        @(posedge clock);
        model_step();
        #1;
        checkOutput("cycle vs model", 32'(dut_vec()), 32'(m_exp));
    endtask

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; add = 1'b0;
        gp = '0; nivel = '0; apr = '0; rep = '0; limpa = '0;
        applyStimulus();
        applyStimulus();
        reset = 1'b1;
        checkOutput("reset state", 32'(dut_vec()), 32'({12'b0, 4'd0, 4'd0, 8'd20, 1'b0, 1'b0}));
    endtask

    task automatic bottle_round(input logic [N-1:0] lanes, input logic [N-1:0] ok);
        int guard;
        start = 1'b1; gp = lanes; nivel = '0;
        applyStimulus();
        nivel = lanes;
        applyStimulus();
        nivel = '0;
        guard = 0;
        while (ved != lanes && guard < 20) begin
            applyStimulus();
            guard++;
        end
        checkOutput("round all lanes sealed", 32'(ved), 32'(lanes));
        apr = ok & lanes; rep = lanes & ~ok;
        applyStimulus();
        apr = '0; rep = '0;
        applyStimulus();
        gp = '0;
        applyStimulus();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global timeout: got running, want finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        tbl[0] = '{1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'd20, 4'd0};
        tbl[1] = '{1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'd20, 4'd0};
        tbl[2] = '{1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'd20, 4'd0};
        tbl[3] = '{1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'd20, 4'd0};
        tbl[4] = '{1'b1, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd20, 4'd0};
        tbl[5] = '{1'b1, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 8'd19, 4'd0};
        tbl[6] = '{1'b1, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 8'd19, 4'd0};
        tbl[7] = '{1'b1, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'd19, 4'd1};
        tbl[8] = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'd19, 4'd1};

        // Single-lane nominal bottle.
        do_reset();
        for (int r = 0; r < 9; r++) begin
            start = tbl[r].st; gp = tbl[r].gp; nivel = tbl[r].niv; apr = tbl[r].apr;
            rep = '0; add = 1'b0; limpa = '0;
            applyStimulus();
            checkOutput($sformatf("vector %0d", r),
                        32'({motor[0], valve[0], ved[0], lac[0], est, ga}),
                        32'({tbl[r].motor0, tbl[r].valve0, tbl[r].ved0, tbl[r].lac0, tbl[r].est, tbl[r].ga}));
        end

        // Two lanes ask for a cork in the same cycle.
        do_reset();
        start = 1'b1; gp = 2'b11; nivel = 2'b00;
        applyStimulus();
        nivel = 2'b11;
        applyStimulus();
        checkOutput("contention both sealing", 32'(ved), 32'(2'b00));
        applyStimulus();
        checkOutput("contention lane0 first", 32'({ved, est}), 32'({2'b01, 8'd19}));
        applyStimulus();
        checkOutput("contention lane1 next", 32'({ved, est}), 32'({2'b11, 8'd18}));
        apr = 2'b11; applyStimulus(); apr = '0;
        applyStimulus();
        gp = '0; applyStimulus();

        // Fill timeout and fault clear.
        do_reset();
        start = 1'b1; gp = 2'b01; nivel = '0;
        for (int c = 0; c < 15; c++) applyStimulus();
        checkOutput("timeout still filling", 32'({falha[0], valve[0]}), 32'({1'b0, 1'b1}));
        applyStimulus();
        checkOutput("timeout fault raised", 32'({falha[0], valve[0], motor[0]}), 32'(3'b100));
        limpa = 2'b01; applyStimulus(); limpa = '0;
        checkOutput("fault cleared to exit", 32'({falha[0], motor[0]}), 32'(2'b01));
        gp = '0; applyStimulus();
        gp = 2'b01; applyStimulus();
        checkOutput("back to idle then fill", 32'(valve[0]), 32'(1'b1));
        start = 1'b0; gp = '0; applyStimulus();

        // Empty stock, refill coinciding with the grant, then saturation.
        do_reset();
        for (int r = 0; r < 10; r++) bottle_round(2'b11, 2'b11);
        checkOutput("stock drained", 32'({est, sem}), 32'({8'd0, 1'b1}));
        gp = 2'b01; applyStimulus();
        nivel = 2'b01; applyStimulus(); nivel = '0;
        for (int c = 0; c < 3; c++) applyStimulus();
        checkOutput("lane waits for cork", 32'({ved[0], est, sem}), 32'({1'b0, 8'd0, 1'b1}));
        add = 1'b1; applyStimulus(); add = 1'b0;
        checkOutput("refill with grant", 32'({ved[0], est, sem}), 32'({1'b1, 8'd19, 1'b0}));
        apr = 2'b01; applyStimulus(); apr = '0;
        applyStimulus();
        gp = '0; applyStimulus();
        add = 1'b1;
        for (int c = 0; c < 8; c++) applyStimulus();
        add = 1'b0;
        checkOutput("stock saturates", 32'(est), 32'(8'd150));

        // Dozen rollover and production target.
        do_reset();
        start = 1'b1; add = 1'b1;
        for (int c = 0; c < 7; c++) applyStimulus();
        add = 1'b0;
        bottle_round(2'b01, 2'b01);
        for (int r = 0; r < 5; r++) bottle_round(2'b11, 2'b11);
        checkOutput("eleven bottles", 32'({ga, du}), 32'({4'd11, 4'd0}));
        bottle_round(2'b11, 2'b11);
        checkOutput("dozen rollover", 32'({ga, du}), 32'({4'd1, 4'd1}));
        for (int r = 0; r < 53; r++) bottle_round(2'b11, 2'b11);
        checkOutput("just before target", 32'({ga, du, meta}), 32'({4'd11, 4'd9, 1'b0}));
        bottle_round(2'b11, 2'b11);
        checkOutput("target reached", 32'({ga, du, meta}), 32'({4'd1, 4'd10, 1'b1}));
        gp = 2'b11;
        for (int c = 0; c < 3; c++) applyStimulus();
        checkOutput("no fills after target", 32'({valve, motor, ga, du}),
                    32'({2'b00, 2'b00, 4'd1, 4'd10}));
        gp = '0; applyStimulus();

        // Reset in the middle of a fill.
        do_reset();
        bottle_round(2'b01, 2'b01);
        gp = 2'b01; applyStimulus();
        checkOutput("filling before reset", 32'({valve[0], est, ga}), 32'({1'b1, 8'd19, 4'd1}));
        reset = 1'b0; applyStimulus(); reset = 1'b1;
        checkOutput("mid-fill reset", 32'({valve, est, ga, du}), 32'({2'b00, 8'd20, 4'd0, 4'd0}));

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(499, 0) != 0);
            start = ($urandom_range(49, 0) != 0);
            add   = ($urandom_range(29, 0) == 0);
            for (int i = 0; i < N; i++) begin
                gp[i]    = ($urandom_range(9, 0) != 0);
                nivel[i] = ($urandom_range(3, 0) == 0);
                apr[i]   = ($urandom_range(2, 0) == 0);
                rep[i]   = ($urandom_range(6, 0) == 0);
                limpa[i] = ($urandom_range(5, 0) == 0);
            end
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
